// File: rtl/rom_loader.sv
// rom_loader: packs ioctl download beats into wide memory words and writes them
// through a toggle req/ack port, stalling the ioctl stream while a write is
// outstanding. A partially filled tail word is flushed with byte enables when the
// download ends. Also reports the loaded size and copier-header presence.
// OUT_W is expected to be at least 16 so the byte-lane index is at least one bit.
`timescale 1ns/1ps
module rom_loader #(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 64,
   parameter int ADDR_W = 25
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   input  logic                 ioctl_download,
   input  logic                 ioctl_wr,
   input  logic [IN_W-1:0]      ioctl_dout,
   output logic                 ioctl_wait,
   input  logic                 swap_bits,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [OUT_W-1:0]     mem_din,
   output logic [OUT_W/8-1:0]   mem_be,
   output logic                 mem_req,
   input  logic                 mem_ack,
   output logic [ADDR_W-1:0]    rom_size,
   output logic                 hdr_detected,
   output logic                 overflow,
   output logic                 done
);

   localparam int NB  = OUT_W / 8;        // byte lanes per memory word
   localparam int BPB = IN_W / 8;         // bytes per ioctl beat
   localparam int LB  = $clog2(NB);       // byte-offset bits inside a word
   localparam logic [LB-1:0] LAST_LANE = LB'(NB - BPB);
   localparam logic [NB-1:0] BEAT_BE   = NB'((1 << BPB) - 1);

   typedef enum logic [2:0] {IDLE, FILL, WAIT_ACK, FLUSH, FLUSH_WAIT} state_t;

   state_t             state;
   state_t             next_state;
   logic               download_q;
   logic [OUT_W-1:0]   pack_buf;
   logic [NB-1:0]      pack_be;
   logic [OUT_W-1:0]   merged_buf;
   logic [NB-1:0]      merged_be;
   logic [IN_W-1:0]    beat_data;
   logic [LB-1:0]      lane;
   logic [ADDR_W-1:0]  word_base;
   logic [ADDR_W:0]    size_sum;
   logic               last_lane;
   logic               ack_match;

   // action strobes decoded from the state machine
   logic               start_dl;
   logic               take_beat;
   logic               issue_word;
   logic               issue_flush;
   logic               release_wait;
   logic               finish;

   // mirror the bit order inside every byte of a beat
   function automatic logic [IN_W-1:0] reverse_bytes(input logic [IN_W-1:0] d);
      logic [IN_W-1:0] r;
      r = '0;
      for (int b = 0; b < BPB; b++) begin
         for (int i = 0; i < 8; i++) begin
            r[b*8 + i] = d[b*8 + 7 - i];
         end
      end
      return r;
   endfunction

   assign lane      = rom_size[LB-1:0];
   assign last_lane = (lane == LAST_LANE);
   assign ack_match = (mem_ack == mem_req);
   assign word_base = {rom_size[ADDR_W-1:LB], {LB{1'b0}}};
   assign size_sum  = {1'b0, rom_size} + (ADDR_W+1)'(BPB);
   assign beat_data = swap_bits ? reverse_bytes(ioctl_dout) : ioctl_dout;

   // merge the incoming beat into its byte lanes of the pack buffer
   always_comb begin
      merged_buf = pack_buf;
      merged_buf[{lane, 3'b000} +: IN_W] = beat_data;
      merged_be  = pack_be | (BEAT_BE << lane);
   end

   // previous download level for edge detection; never reset so a transfer
   // still running across a reset is not mistaken for a fresh one
   always_ff @(posedge clk_sys) begin
      download_q <= ioctl_download;
   end

   // state register
   always_ff @(posedge clk_sys) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // next-state decode
   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (ioctl_download && !download_q) next_state = FILL;
         FILL: begin
            if (!ioctl_download)                next_state = (|pack_be) ? FLUSH : IDLE;
            else if (ioctl_wr && last_lane)     next_state = WAIT_ACK;
         end
         WAIT_ACK:   if (ack_match) next_state = FILL;
         FLUSH:      next_state = FLUSH_WAIT;
         FLUSH_WAIT: if (ack_match) next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   // output decode: per-state action strobes for the datapath
   always_comb begin
      start_dl     = 1'b0;
      take_beat    = 1'b0;
      issue_word   = 1'b0;
      issue_flush  = 1'b0;
      release_wait = 1'b0;
      finish       = 1'b0;
      case (state)
         IDLE: start_dl = ioctl_download && !download_q;
         FILL: begin
            if (!ioctl_download) begin
               finish = ~|pack_be;
            end else if (ioctl_wr) begin
               take_beat  = 1'b1;
               issue_word = last_lane;
            end
         end
         WAIT_ACK:   release_wait = ack_match;
         FLUSH:      issue_flush  = 1'b1;
         FLUSH_WAIT: finish       = ack_match;
         default: ;
      endcase
   end

   // datapath and handshake registers; reset abandons any partial word
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ioctl_wait   <= 1'b0;
         mem_req      <= mem_ack;
         mem_be       <= '0;
         mem_addr     <= '0;
         mem_din      <= '0;
         rom_size     <= '0;
         hdr_detected <= 1'b0;
         overflow     <= 1'b0;
         done         <= 1'b0;
         pack_buf     <= '0;
         pack_be      <= '0;
      end else begin
         done <= finish;
         if (start_dl) begin
            rom_size     <= '0;
            pack_buf     <= '0;
            pack_be      <= '0;
            overflow     <= 1'b0;
            hdr_detected <= 1'b0;
         end
         if (take_beat) begin
            rom_size <= size_sum[ADDR_W-1:0];
            if (size_sum[ADDR_W]) overflow <= 1'b1;
            pack_buf <= merged_buf;
            pack_be  <= merged_be;
         end
         if (issue_word) begin
            mem_addr   <= word_base;
            mem_din    <= merged_buf;
            mem_be     <= merged_be;
            mem_req    <= ~mem_req;
            ioctl_wait <= 1'b1;
         end
         if (issue_flush) begin
            mem_addr <= word_base;
            mem_din  <= pack_buf;
            mem_be   <= pack_be;
            mem_req  <= ~mem_req;
         end
         if (release_wait) begin
            ioctl_wait <= 1'b0;
            pack_buf   <= '0;
            pack_be    <= '0;
         end
         if (finish) hdr_detected <= rom_size[9];
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed bench for rom_loader (IN_W=16, OUT_W=64, ADDR_W=25)
// with a toggle-handshake memory responder that records every write.
`timescale 1ns/1ps
module tb_rom_loader;

   localparam int IN_W   = 16;
   localparam int OUT_W  = 64;
   localparam int ADDR_W = 25;

   logic                clk_sys = 1'b0;
   logic                reset;
   logic                ioctl_download;
   logic                ioctl_wr;
   logic [IN_W-1:0]     ioctl_dout;
   logic                ioctl_wait;
   logic                swap_bits;
   logic [ADDR_W-1:0]   mem_addr;
   logic [OUT_W-1:0]    mem_din;
   logic [OUT_W/8-1:0]  mem_be;
   logic                mem_req;
   logic                mem_ack = 1'b0;
   logic [ADDR_W-1:0]   rom_size;
   logic                hdr_detected;
   logic                overflow;
   logic                done;

   int checks = 0;
   int errors = 0;

   rom_loader #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .swap_bits(swap_bits), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_be(mem_be), .mem_req(mem_req), .mem_ack(mem_ack),
      .rom_size(rom_size), .hdr_detected(hdr_detected), .overflow(overflow),
      .done(done)
   );

   always #5 clk_sys = ~clk_sys;

   // memory responder: records each request, acknowledges after ack_delay cycles
   bit                  auto_ack = 1'b1;
   int                  ack_delay = 0;
   bit                  pending = 1'b0;
   int                  cnt = 0;
   logic [ADDR_W-1:0]   cap_addr[$];
   logic [OUT_W-1:0]    cap_din[$];
   logic [OUT_W/8-1:0]  cap_be[$];

   always @(posedge clk_sys) begin
      if (pending) begin
         if (cnt == 0) begin
            mem_ack <= mem_req;
            pending = 1'b0;
         end else begin
            cnt--;
         end
      end else if (auto_ack && (mem_req !== mem_ack)) begin
         cap_addr.push_back(mem_addr);
         cap_din.push_back(mem_din);
         cap_be.push_back(mem_be);
         pending = 1'b1;
         cnt = ack_delay;
      end
   end

   task automatic clear_caps();
      cap_addr.delete();
      cap_din.delete();
      cap_be.delete();
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ioctl_wait && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      if (ioctl_wait) begin
         checks++; errors++;
         $display("FAIL wait_ready: ioctl_wait still high after %0d cycles, required low", n);
      end
   endtask

   task automatic send_beat(input logic [IN_W-1:0] d);
      wait_ready();
      ioctl_wr   = 1'b1;
      ioctl_dout = d;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
   endtask

   task automatic start_dl();
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic end_dl(input bit wait_first, output int dones);
      if (wait_first) wait_ready();
      ioctl_download = 1'b0;
      dones = 0;
      repeat (60) begin
         @(negedge clk_sys);
         if (done) dones++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_dout = '0;
      swap_bits = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", ioctl_wait); end
      checks++; if (mem_be !== 8'h00) begin errors++; $display("FAIL reset_be: got %h want 00", mem_be); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
      checks++; if (mem_din !== '0) begin errors++; $display("FAIL reset_din: got %h want 0", mem_din); end
      checks++; if (rom_size !== '0) begin errors++; $display("FAIL reset_size: got %h want 0", rom_size); end
      checks++; if ({hdr_detected, overflow, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {hdr_detected, overflow, done}); end
      checks++; if (mem_req !== mem_ack) begin errors++; $display("FAIL reset_req: req %b ack %b, required equal", mem_req, mem_ack); end
   endtask

   task automatic test_single_word();
      int d;
      clear_caps();
      start_dl();
      send_beat(16'h0100); send_beat(16'h0302); send_beat(16'h0504); send_beat(16'h0706);
      end_dl(1'b1, d);
      checks++; if (cap_din.size() != 1) begin errors++; $display("FAIL single_count: got %0d writes want 1", cap_din.size()); end
      if (cap_din.size() >= 1) begin
         checks++; if (cap_addr[0] !== 25'h0) begin errors++; $display("FAIL single_addr: got %h want 0", cap_addr[0]); end
         checks++; if (cap_din[0] !== 64'h0706050403020100) begin errors++; $display("FAIL single_din: got %h want 0706050403020100", cap_din[0]); end
         checks++; if (cap_be[0] !== 8'hFF) begin errors++; $display("FAIL single_be: got %h want FF", cap_be[0]); end
      end
      checks++; if (rom_size !== 25'd8) begin errors++; $display("FAIL single_size: got %0d want 8", rom_size); end
      checks++; if (d != 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", d); end
      checks++; if ({hdr_detected, overflow} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b want 00", {hdr_detected, overflow}); end
   endtask

   task automatic test_swap();
      int d;
      clear_caps();
      swap_bits = 1'b1;
      start_dl();
      send_beat(16'h8001); send_beat(16'h0201); send_beat(16'hF00F); send_beat(16'h5533);
      end_dl(1'b1, d);
      swap_bits = 1'b0;
      checks++; if (cap_din.size() != 1) begin errors++; $display("FAIL swap_count: got %0d writes want 1", cap_din.size()); end
      if (cap_din.size() >= 1) begin
         checks++; if (cap_din[0] !== 64'hAACC0FF040800180) begin errors++; $display("FAIL swap_din: got %h want AACC0FF040800180", cap_din[0]); end
      end
   endtask

   task automatic test_partial();
      int d;
      clear_caps();
      start_dl();
      send_beat(16'h0100); send_beat(16'h0302); send_beat(16'h0504); send_beat(16'h0706);
      send_beat(16'h0908);
      end_dl(1'b1, d);
      checks++; if (cap_din.size() != 2) begin errors++; $display("FAIL partial_count: got %0d writes want 2", cap_din.size()); end
      if (cap_din.size() >= 2) begin
         checks++; if (cap_addr[0] !== 25'h0 || cap_be[0] !== 8'hFF) begin errors++; $display("FAIL partial_w0: addr %h be %h, want 0 FF", cap_addr[0], cap_be[0]); end
         checks++; if (cap_addr[1] !== 25'h8 || cap_be[1] !== 8'h03) begin errors++; $display("FAIL partial_w1: addr %h be %h, want 8 03", cap_addr[1], cap_be[1]); end
         checks++; if (cap_din[1] !== 64'h0000000000000908) begin errors++; $display("FAIL partial_din: got %h want 0000000000000908", cap_din[1]); end
      end
      checks++; if (d != 1) begin errors++; $display("FAIL partial_done: got %0d pulses want 1", d); end
      checks++; if (rom_size !== 25'd10) begin errors++; $display("FAIL partial_size: got %0d want 10", rom_size); end
   endtask

   task automatic test_slow_ack();
      int d;
      int ack_at = -1;
      int fall_at = -1;
      clear_caps();
      ack_delay = 20;
      start_dl();
      send_beat(16'h1110); send_beat(16'h1312); send_beat(16'h1514); send_beat(16'h1716);
      checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL slow_wait_rise: got %b want 1", ioctl_wait); end
      // stray strobe while stalled must be dropped
      ioctl_wr = 1'b1; ioctl_dout = 16'hDEAD;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ack_at < 0 && mem_ack === mem_req) ack_at = i;
         if (!ioctl_wait) begin fall_at = i; break; end
         @(negedge clk_sys);
      end
      checks++; if (ack_at < 20) begin errors++; $display("FAIL slow_ack_time: ack seen at %0d, required >= 20", ack_at); end
      checks++; if (fall_at != ack_at + 1) begin errors++; $display("FAIL slow_wait_fall: wait fell at %0d, required %0d", fall_at, ack_at + 1); end
      send_beat(16'h1918); send_beat(16'h1B1A); send_beat(16'h1D1C); send_beat(16'h1F1E);
      end_dl(1'b0, d);
      ack_delay = 0;
      checks++; if (cap_din.size() != 2) begin errors++; $display("FAIL slow_count: got %0d writes want 2", cap_din.size()); end
      if (cap_din.size() >= 2) begin
         checks++; if (cap_din[0] !== 64'h1716151413121110) begin errors++; $display("FAIL slow_din0: got %h want 1716151413121110", cap_din[0]); end
         checks++; if (cap_din[1] !== 64'h1F1E1D1C1B1A1918 || cap_addr[1] !== 25'h8) begin errors++; $display("FAIL slow_din1: got %h @%h want 1F1E1D1C1B1A1918 @8", cap_din[1], cap_addr[1]); end
      end
      checks++; if (rom_size !== 25'd16) begin errors++; $display("FAIL slow_size: got %0d want 16", rom_size); end
      checks++; if (d != 1) begin errors++; $display("FAIL slow_done: got %0d pulses want 1", d); end
   endtask

   task automatic test_header();
      int d;
      logic [7:0] b;
      clear_caps();
      start_dl();
      for (int k = 0; k < 264; k++) begin
         b = 8'(2 * k);
         send_beat({b + 8'd1, b});
      end
      end_dl(1'b1, d);
      checks++; if (rom_size !== 25'd528) begin errors++; $display("FAIL hdr528_size: got %0d want 528", rom_size); end
      checks++; if (hdr_detected !== 1'b1) begin errors++; $display("FAIL hdr528_flag: got %b want 1", hdr_detected); end
      checks++; if (cap_din.size() != 66) begin errors++; $display("FAIL hdr528_count: got %0d writes want 66", cap_din.size()); end
      if (cap_din.size() == 66) begin
         checks++; if (cap_addr[65] !== 25'h208 || cap_din[65] !== 64'h0F0E0D0C0B0A0908) begin errors++; $display("FAIL hdr528_last: got %h @%h want 0F0E0D0C0B0A0908 @208", cap_din[65], cap_addr[65]); end
      end
      checks++; if (d != 1) begin errors++; $display("FAIL hdr528_done: got %0d pulses want 1", d); end
      clear_caps();
      start_dl();
      for (int k = 0; k < 512; k++) send_beat(16'(k));
      end_dl(1'b1, d);
      checks++; if (rom_size !== 25'd1024) begin errors++; $display("FAIL hdr1024_size: got %0d want 1024", rom_size); end
      checks++; if (hdr_detected !== 1'b0) begin errors++; $display("FAIL hdr1024_flag: got %b want 0", hdr_detected); end
      checks++; if (cap_din.size() != 128) begin errors++; $display("FAIL hdr1024_count: got %0d writes want 128", cap_din.size()); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hdr1024_ovf: got %b want 0", overflow); end
   endtask

   task automatic test_reset_wait_ack();
      int d = 0;
      clear_caps();
      auto_ack = 1'b0;
      start_dl();
      send_beat(16'h2120); send_beat(16'h2322); send_beat(16'h2524); send_beat(16'h2726);
      checks++; if (ioctl_wait !== 1'b1 || mem_req === mem_ack) begin errors++; $display("FAIL rst_pre: wait %b req %b ack %b, want wait 1 and req != ack", ioctl_wait, mem_req, mem_ack); end
      reset = 1'b1;
      @(negedge clk_sys);
      checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL rst_wait: got %b want 0", ioctl_wait); end
      checks++; if (mem_req !== mem_ack) begin errors++; $display("FAIL rst_req: req %b ack %b, required equal", mem_req, mem_ack); end
      checks++; if (rom_size !== '0 || mem_be !== 8'h00) begin errors++; $display("FAIL rst_clear: size %0d be %h, want 0 00", rom_size, mem_be); end
      reset = 1'b0;
      send_beat(16'hAAAA);
      repeat (5) @(negedge clk_sys);
      checks++; if (rom_size !== '0) begin errors++; $display("FAIL rst_idle: beat taken, size %0d want 0", rom_size); end
      checks++; if (mem_req !== mem_ack) begin errors++; $display("FAIL rst_no_req: req %b ack %b, required equal", mem_req, mem_ack); end
      ioctl_download = 1'b0;
      repeat (10) begin
         @(negedge clk_sys);
         if (done) d++;
      end
      checks++; if (d != 0) begin errors++; $display("FAIL rst_done: got %0d pulses want 0", d); end
      checks++; if (cap_din.size() != 0) begin errors++; $display("FAIL rst_writes: got %0d writes want 0", cap_din.size()); end
      auto_ack = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_swap();
      test_partial();
      test_slow_ack();
      test_header();
      test_reset_wait_ack();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
